// File: rtl/calc_tx_serializer_pkg.sv
// calc_pkg: shared types and helpers for the result-frame transmitter.
//   tx_state_t : transmit FSM states (idle / shifting a frame out)
//   tx_beats   : number of SBITS-wide beats in a FRAME_BITS-wide frame
//   cnt_width  : counter width able to hold 0..n-1 (never below 1 bit)
`timescale 1ns/1ps
package calc_pkg;

  typedef enum logic {
    TX_IDLE  = 1'b0,
    TX_SHIFT = 1'b1
  } tx_state_t;

  function automatic int tx_beats(input int frame_bits, input int sbits);
    return frame_bits / sbits;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/calc_tx_serializer_if.sv
// calc_tx_serializer_if: load / config / serial-output bundle of the transmitter.
//   master modport : the side that offers frames and configures the divider
//   slave modport  : the transmitter itself
// Signals:
//   ConfigDiv/DivIn         divider write strobe and value (0 is stored as 1)
//   LoadValid/LoadReady     frame handshake, LoadData + LsbFirst captured together
//   Busy                    shifting or a frame waiting in the holding buffer
//   ClkTx/DoutValid/DataOut serial output (receiver samples on ClkTx rise)
//   ConfigErr               one-cycle pulse when a divider write was refused
`timescale 1ns/1ps
interface calc_tx_serializer_if #(
  parameter int FRAME_BITS = 32,
  parameter int SBITS      = 4,
  parameter int DIVW       = 8
);
  logic                  ConfigDiv;
  logic [DIVW-1:0]       DivIn;
  logic                  LoadValid;
  logic                  LoadReady;
  logic [FRAME_BITS-1:0] LoadData;
  logic                  LsbFirst;
  logic                  Busy;
  logic                  ClkTx;
  logic                  DoutValid;
  logic [SBITS-1:0]      DataOut;
  logic                  ConfigErr;

  modport master (
    output ConfigDiv, DivIn, LoadValid, LoadData, LsbFirst,
    input  LoadReady, Busy, ClkTx, DoutValid, DataOut, ConfigErr
  );

  modport slave (
    input  ConfigDiv, DivIn, LoadValid, LoadData, LsbFirst,
    output LoadReady, Busy, ClkTx, DoutValid, DataOut, ConfigErr
  );
endinterface

// File: rtl/calc_tx_serializer_clk_div.sv
// calc_clk_div: programmable divider for the transmit clock.
//   clk, rst  : system clock, asynchronous active-high reset
//   cfg_we    : write cfg_val into the divider register (0 is stored as 1)
//   cfg_val   : new divider value
//   clear     : restart the half-period count (a frame is being loaded)
//   run       : count only while a frame is shifting
//   tick      : last cycle of a half period of ClkTx (DIV cycles long)
`timescale 1ns/1ps
module calc_clk_div #(
  parameter int DIVW      = 8,
  parameter int DIV_RESET = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [DIVW-1:0] cfg_val,
  input  logic            clear,
  input  logic            run,
  output logic            tick
);

  if ((DIV_RESET < 1) || (DIV_RESET > (2**DIVW) - 1)) begin : g_bad_div_reset
    $error("DIV_RESET must lie in 1..2**DIVW-1");
  end

  logic [DIVW-1:0] div_reg_q, div_reg_d;
  logic [DIVW-1:0] div_cnt_q, div_cnt_d;

  assign tick = run && (div_cnt_q == (div_reg_q - DIVW'(1)));

  always_comb begin
    div_reg_d = div_reg_q;
    if (cfg_we) begin
      div_reg_d = (cfg_val == '0) ? DIVW'(1) : cfg_val;
    end
    div_cnt_d = div_cnt_q + DIVW'(1);
    if (clear || !run || tick) begin
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg_q <= DIVW'(DIV_RESET);
      div_cnt_q <= '0;
    end else begin
      div_reg_q <= div_reg_d;
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/calc_tx_serializer.sv
// calc_tx_serializer: result-frame transmitter.
//   Clk   : system clock, rising edge
//   Reset : asynchronous active-high reset; a frame in flight is dropped
//   bus   : calc_tx_serializer_if.slave (load handshake, divider config, serial out)
// A one-entry holding buffer accepts a frame while the previous one shifts,
// so back-to-back frames go out without a gap. Each beat spends DIV cycles
// with ClkTx low, then DIV cycles high; DataOut only moves on ClkTx fall.
`timescale 1ns/1ps
module calc_tx_serializer
  import calc_pkg::*;
#(
  parameter int FRAME_BITS = 32,
  parameter int SBITS      = 4,
  parameter int DIVW       = 8,
  parameter int DIV_RESET  = 1
) (
  input logic                 Clk,
  input logic                 Reset,
  calc_tx_serializer_if.slave bus
);

  localparam int NB  = tx_beats(FRAME_BITS, SBITS);
  localparam int BCW = cnt_width(NB);

  if ((FRAME_BITS % SBITS) != 0) begin : g_bad_frame
    $error("FRAME_BITS must be a multiple of SBITS");
  end

  tx_state_t             state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  lsb_q, lsb_d;
  logic [BCW-1:0]        beat_cnt_q, beat_cnt_d;
  logic                  clk_tx_q, clk_tx_d;
  logic                  dout_valid_q, dout_valid_d;
  logic [SBITS-1:0]      data_out_q, data_out_d;
  logic                  config_err_q, config_err_d;
  logic                  hold_full_q, hold_full_d;
  logic [FRAME_BITS-1:0] hold_data_q, hold_data_d;
  logic                  hold_lsb_q, hold_lsb_d;

  logic busy;
  logic accept;
  logic load;
  logic cfg_we;
  logic div_tick;

  assign busy   = (state_q != TX_IDLE) || hold_full_q;
  assign accept = bus.LoadValid && !hold_full_q;

  calc_clk_div #(
    .DIVW      (DIVW),
    .DIV_RESET (DIV_RESET)
  ) u_clk_div (
    .clk     (Clk),
    .rst     (Reset),
    .cfg_we  (cfg_we),
    .cfg_val (bus.DivIn),
    .clear   (load),
    .run     (state_q == TX_SHIFT),
    .tick    (div_tick)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    lsb_d       = lsb_q;
    beat_cnt_d  = beat_cnt_q;
    clk_tx_d    = clk_tx_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    hold_lsb_d  = hold_lsb_q;
    load        = 1'b0;

    case (state_q)
      TX_IDLE: begin
        if (hold_full_q) begin
          load = 1'b1;
        end
      end
      TX_SHIFT: begin
        if (div_tick) begin
          if (!clk_tx_q) begin
            // end of low phase: receiver samples on this rise
            clk_tx_d = 1'b1;
          end else if (beat_cnt_q == BCW'(NB - 1)) begin
            // end of the final high phase: chain the held frame or go idle
            if (hold_full_q) begin
              load = 1'b1;
            end else begin
              state_d    = TX_IDLE;
              beat_cnt_d = '0;
              clk_tx_d   = 1'b0;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + BCW'(1);
            clk_tx_d   = 1'b0;
            // the outgoing beat always sits at the end being presented
            shift_d    = lsb_q ? (shift_q >> SBITS) : (shift_q << SBITS);
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // load needs a full buffer and accept needs an empty one, so they never coincide
    if (load) begin
      state_d     = TX_SHIFT;
      shift_d     = hold_data_q;
      lsb_d       = hold_lsb_q;
      beat_cnt_d  = '0;
      clk_tx_d    = 1'b0;
      hold_full_d = 1'b0;
    end else if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = bus.LoadData;
      hold_lsb_d  = bus.LsbFirst;
    end

    dout_valid_d = (state_d == TX_SHIFT);
    data_out_d   = '0;
    if (dout_valid_d) begin
      data_out_d = lsb_d ? shift_d[SBITS-1:0] : shift_d[FRAME_BITS-1 -: SBITS];
    end

    // divider only changes between frames, so a write while busy is refused
    cfg_we       = bus.ConfigDiv && !busy;
    config_err_d = bus.ConfigDiv && busy;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= TX_IDLE;
      shift_q      <= '0;
      lsb_q        <= 1'b0;
      beat_cnt_q   <= '0;
      clk_tx_q     <= 1'b0;
      dout_valid_q <= 1'b0;
      data_out_q   <= '0;
      config_err_q <= 1'b0;
      hold_full_q  <= 1'b0;
      hold_data_q  <= '0;
      hold_lsb_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      lsb_q        <= lsb_d;
      beat_cnt_q   <= beat_cnt_d;
      clk_tx_q     <= clk_tx_d;
      dout_valid_q <= dout_valid_d;
      data_out_q   <= data_out_d;
      config_err_q <= config_err_d;
      hold_full_q  <= hold_full_d;
      hold_data_q  <= hold_data_d;
      hold_lsb_q   <= hold_lsb_d;
    end
  end

  assign bus.LoadReady = !hold_full_q;
  assign bus.Busy      = busy;
  assign bus.ClkTx     = clk_tx_q;
  assign bus.DoutValid = dout_valid_q;
  assign bus.DataOut   = data_out_q;
  assign bus.ConfigErr = config_err_q;

endmodule

// File: tb/tb_calc_tx_serializer.sv
`timescale 1ns/1ps
module tb_calc_tx_serializer;
  localparam int FB   = 32;
  localparam int SB   = 4;
  localparam int DW   = 8;
  localparam int DIVR = 1;
  localparam int NB   = FB / SB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  calc_tx_serializer_if #(.FRAME_BITS(FB), .SBITS(SB), .DIVW(DW)) bus ();

  calc_tx_serializer #(
    .FRAME_BITS(FB), .SBITS(SB), .DIVW(DW), .DIV_RESET(DIVR)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [FB-1:0] frame;
    logic          lsb;
    int            div;
    logic [FB-1:0] exp_seq;   // expected beats, first beat in the top nibble
    int            exp_len;   // expected DoutValid cycles
  } vec_t;

  vec_t vecs[5];

  int checks = 0;
  int errors = 0;

  // receiver-side monitor state
  logic [SB-1:0] rx_q[$];
  logic [SB-1:0] exp_q[$];
  int   dv_count = 0, dv_falls = 0, rise_bad = 0, chg_bad = 0, idle_bad = 0;
  int   cyc = 0, exp_div = 1;
  logic prev_dv = 1'b0, prev_ctx = 1'b0;
  logic [SB-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (bus.DoutValid) begin
      dv_count++;
      if (!prev_dv || (prev_ctx && !bus.ClkTx)) cyc = 0;
      else cyc++;
      if (bus.ClkTx && !prev_ctx) begin
        rx_q.push_back(bus.DataOut);
        if (cyc != exp_div) rise_bad++;
      end
      if (prev_dv && (bus.DataOut != prev_data) && !(prev_ctx && !bus.ClkTx)) chg_bad++;
    end else if (bus.ClkTx || (bus.DataOut != '0)) begin
      idle_bad++;
    end
    if (prev_dv && !bus.DoutValid) dv_falls++;
    prev_dv   = bus.DoutValid;
    prev_ctx  = bus.ClkTx;
    prev_data = bus.DataOut;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    rx_q.delete();
    exp_q.delete();
    dv_count = 0;
    dv_falls = 0;
    rise_bad = 0;
    chg_bad  = 0;
  endtask

  // reference: beat i is a SB-wide slice of the frame counted from either end
  task automatic model(input logic [FB-1:0] f, input logic l);
    for (int i = 0; i < NB; i++) begin
      int sh;
      sh = l ? i * SB : FB - (i + 1) * SB;
      exp_q.push_back(SB'(f >> sh));
    end
  endtask

  task automatic send(input logic [FB-1:0] f, input logic l);
    int n = 0;
    while (!bus.LoadReady && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("load_ready_timeout", 64'd1, 64'd0);
    bus.LoadValid = 1'b1;
    bus.LoadData  = f;
    bus.LsbFirst  = l;
    @(posedge clk);
    #1 bus.LoadValid = 1'b0;
    $display("load frame %h lsb_first=%0d at %0t", f, l, $time);
  endtask

  task automatic config_div(input logic [DW-1:0] v);
    bus.ConfigDiv = 1'b1;
    bus.DivIn     = v;
    @(posedge clk);
    #1 bus.ConfigDiv = 1'b0;
    check("cfg_err_idle", 64'(bus.ConfigErr), 64'd0);
    $display("config DivIn=%0d at %0t", v, $time);
  endtask

  task automatic finish_frames(input string name, input int exp_len);
    int n = 0;
    int mism = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.Busy || bus.DoutValid) && n < 5000);
    #1;
    check({name, "_idle"},   64'(bus.Busy | bus.DoutValid), 64'd0);
    check({name, "_len"},    64'(dv_count), 64'(exp_len));
    check({name, "_gaps"},   64'(dv_falls), 64'd1);
    check({name, "_rise"},   64'(rise_bad), 64'd0);
    check({name, "_chg"},    64'(chg_bad), 64'd0);
    check({name, "_nbeats"}, 64'(rx_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      if (rx_q[i] !== exp_q[i]) mism++;
    check({name, "_beats"},  64'(mism), 64'd0);
    check({name, "_dout0"},  64'(bus.DataOut), 64'd0);
    $display("%s: %0d beats, %0d valid cycles, DIV=%0d", name, rx_q.size(), dv_count, exp_div);
  endtask

  initial begin
    logic [FB-1:0] fr[2];
    logic          lr[2];
    logic [FB-1:0] seq;
    int            n;
    int            div;
    int            nfr;

    bus.ConfigDiv = 1'b0;
    bus.DivIn     = '0;
    bus.LoadValid = 1'b0;
    bus.LoadData  = '0;
    bus.LsbFirst  = 1'b0;

    // reset values
    #1 rst = 1'b1;
    #1;
    check("rst_load_ready", 64'(bus.LoadReady), 64'd1);
    check("rst_busy",       64'(bus.Busy), 64'd0);
    check("rst_clktx",      64'(bus.ClkTx), 64'd0);
    check("rst_dvalid",     64'(bus.DoutValid), 64'd0);
    check("rst_dout",       64'(bus.DataOut), 64'd0);
    check("rst_cfg_err",    64'(bus.ConfigErr), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // table-driven single frames
    vecs[0] = '{32'hA5C31E70, 1'b0, 3, 32'hA5C31E70, 48};
    vecs[1] = '{32'hA5C31E70, 1'b1, 3, 32'h07E13C5A, 48};
    vecs[2] = '{32'hDEADBEEF, 1'b0, 1, 32'hDEADBEEF, 16};
    vecs[3] = '{32'h12345678, 1'b1, 2, 32'h87654321, 32};
    vecs[4] = '{32'hF00F0FF0, 1'b1, 4, 32'h0FF0F00F, 64};
    for (int v = 0; v < 5; v++) begin
      clear_mon();
      exp_div = vecs[v].div;
      config_div(DW'(vecs[v].div));
      seq = vecs[v].exp_seq;
      for (int i = 0; i < NB; i++) exp_q.push_back(seq[FB-1-SB*i -: SB]);
      send(vecs[v].frame, vecs[v].lsb);
      finish_frames($sformatf("vec%0d", v), vecs[v].exp_len);
    end

    // back-to-back frames through the holding buffer
    clear_mon();
    exp_div = 3;
    config_div(8'd3);
    model(32'h11112222, 1'b0);
    model(32'h33334444, 1'b0);
    send(32'h11112222, 1'b0);
    send(32'h33334444, 1'b0);
    check("b2b_ready_held", 64'(bus.LoadReady), 64'd0);
    n = 0;
    while (!bus.LoadReady && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b2b_ready_return", 64'(n), 64'(NB * 2 * 3));
    finish_frames("b2b", 2 * NB * 2 * 3);

    // divider write while shifting is refused
    clear_mon();
    exp_div = 3;
    model(32'hC0FFEE42, 1'b0);
    send(32'hC0FFEE42, 1'b0);
    repeat (10) @(negedge clk);
    bus.ConfigDiv = 1'b1;
    bus.DivIn     = 8'd5;
    @(posedge clk);
    #1 check("cfg_err_pulse", 64'(bus.ConfigErr), 64'd1);
    bus.ConfigDiv = 1'b0;
    @(posedge clk);
    #1 check("cfg_err_clear", 64'(bus.ConfigErr), 64'd0);
    finish_frames("cfg_busy", NB * 2 * 3);

    // DivIn = 0 while idle is stored as 1
    clear_mon();
    exp_div = 1;
    config_div(8'd0);
    model(32'h0F1E2D3C, 1'b1);
    send(32'h0F1E2D3C, 1'b1);
    finish_frames("cfg_zero", NB * 2 * 1);

    // asynchronous reset mid-frame with a second frame held
    clear_mon();
    exp_div = 3;
    config_div(8'd3);
    send(32'hA5C31E70, 1'b0);
    send(32'h5A5A5A5A, 1'b1);
    n = 0;
    while (rx_q.size() < 3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("rst_beat3_reached", 64'(rx_q.size() >= 3), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_load_ready", 64'(bus.LoadReady), 64'd1);
    check("rst_mid_busy",       64'(bus.Busy), 64'd0);
    check("rst_mid_clktx",      64'(bus.ClkTx), 64'd0);
    check("rst_mid_dvalid",     64'(bus.DoutValid), 64'd0);
    check("rst_mid_dout",       64'(bus.DataOut), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_mon();
    repeat (150) @(negedge clk);
    #1 check("rst_no_resume", 64'(dv_count), 64'd0);
    clear_mon();
    exp_div = DIVR;
    model(32'h76543210, 1'b0);
    send(32'h76543210, 1'b0);
    finish_frames("rst_div_reset", NB * 2 * DIVR);

    // divider write and frame acceptance in the same idle cycle
    clear_mon();
    exp_div = 2;
    model(32'h9ABCDEF0, 1'b1);
    bus.ConfigDiv = 1'b1;
    bus.DivIn     = 8'd2;
    bus.LoadValid = 1'b1;
    bus.LoadData  = 32'h9ABCDEF0;
    bus.LsbFirst  = 1'b1;
    @(posedge clk);
    #1;
    bus.ConfigDiv = 1'b0;
    bus.LoadValid = 1'b0;
    $display("load frame 9abcdef0 with DivIn=2 at %0t", $time);
    finish_frames("cfg_and_load", NB * 2 * 2);

    // randomized frames, one or two back-to-back per run
    for (int r = 0; r < 10; r++) begin
      clear_mon();
      div = int'($urandom_range(1, 4));
      nfr = int'($urandom_range(1, 2));
      exp_div = div;
      config_div(DW'(div));
      for (int k = 0; k < nfr; k++) begin
        fr[k] = $urandom;
        lr[k] = 1'($urandom_range(0, 1));
        model(fr[k], lr[k]);
      end
      for (int k = 0; k < nfr; k++) send(fr[k], lr[k]);
      finish_frames($sformatf("rnd%0d", r), nfr * NB * 2 * div);
    end

    check("idle_outputs_quiet", 64'(idle_bad), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
